flac_subframe_decoder: RTL and testbench
========================================

# flac_subframe_decoder

Decodes one FLAC audio subframe (16-bit samples, one channel) from a bitstream held in an external synchronous RAM and emits the reconstructed PCM samples one at a time. It supports CONSTANT, VERBATIM and FIXED (orders 0–4) subframes with partitioned Rice/Rice2 residuals. It sits between the frame-buffer RAM (1-cycle read latency, 16-bit words, MSB-first bitstream) and the downstream sample sink.

## Interface
- No parameters; sample width is fixed at 16 bits and arithmetic width at 32 bits.
- iClock  in  1  rising-edge clock.
- iReset  in  1  asynchronous, active-low reset.
- iEnable  in  1  high = run; low = hold all state, including the RAM address.
- iBlockSize  in  16  number of samples in the subframe, 1..65535; sampled while idle after reset.
- iData  in  16  RAM read data; valid one cycle after the oReadAddr it answers.
- oReadAddr  out  16  RAM word address; starts at 0 and never decrements.
- oSample  out  16 signed  decoded sample.
- oSampleValid  out  1  one-cycle strobe; oSample is valid in that cycle.
- oFrameDone  out  1  one-cycle strobe; the subframe is finished.

## Operation
- Bitstream starts at word 0, bit 15. Bits are consumed MSB-first, and words are fetched sequentially through a bit-reader with a one-word prefetch.
- Header is 8 bits: pad (ignored), 6-bit type, wasted-bits flag (must be 0; if set, the flag is ignored).
  - 000000 CONSTANT: read one 16-bit value and output it iBlockSize times.
  - 000001 VERBATIM: output iBlockSize raw 16-bit samples.
  - 001ooo FIXED with order o ≤ 4: output o raw 16-bit warm-up samples, then decode the residual.
  - Any other type, or FIXED o > 4, is unsupported: output no samples and pulse oFrameDone.
- Residual coding:
  - Header fields: 2-bit method (00 = 4-bit Rice parameter, 01 = 5-bit; 1x is treated as unsupported), then 4-bit partition order p.
  - There are 2^p partitions. Each holds iBlockSize>>p residuals; partition 0 holds (iBlockSize>>p) − o.
  - Each partition begins with a Rice parameter k.
    - If k is all-ones (15 or 31), it is an escape: a 5-bit n follows, then the residuals as n-bit two's-complement values. n = 0 means all residuals are 0.
    - Otherwise each residual is a unary quotient q (count of 0s before a terminating 1) followed by a k-bit remainder r. Compute u = (q<<k)|r, then e = (u>>1) XOR −(u&1).
- Prediction uses s1..s4 = previous outputs, held at 32 bits:
  - o0: 0.
  - o1: s1.
  - o2: 2s1−s2.
  - o3: 3s1−3s2+s3.
  - o4: 4s1−6s2+4s3−s4.
  - Sample = prediction + e, computed at 32 bits. oSample is the low 16 bits.
- State machine: IDLE → HEADER → {CONST | VERBATIM | WARMUP → RESID_HDR → PART_HDR → RESIDUAL (loops back to PART_HDR per partition)} → DONE.
- DONE pulses oFrameDone once and then remains silent until reset.

## Timing
- Reset values:
  - oSample = 0, oSampleValid = 0, oFrameDone = 0, oReadAddr = 0.
  - State = IDLE; history registers = 0.
- Decoding starts on the first clock with iReset high and iEnable high.
- RAM contract: data for address A appears on iData on the cycle after oReadAddr = A. The decoder must not use iData in the same cycle it issues the address.
- Bit consumption:
  - At most one sample per cycle.
  - Each sample completes within (encoded bit count + 4) cycles of the previous one.
  - A word refill never loses or duplicates a bit, including when a field straddles a word boundary.
- Strobes:
  - oSampleValid pulses exactly iBlockSize times.
  - oFrameDone pulses one cycle after the last oSampleValid. For unsupported types it pulses within 4 cycles after the header is read.
- iEnable low: no state or address change. Strobes are held low and resume without loss.
- Reset assertion mid-frame: outputs clear immediately (asynchronously), and decoding restarts from word 0 after release.

## Test plan
- CONSTANT: RAM 0x00FF, 0xFE00, iBlockSize=4 → four samples of −2, then one oFrameDone.
- VERBATIM: header 0x02, then samples 0x7FFF, 0x8000, 0x0001 with iBlockSize=3 → 32767, −32768, 1, done.
- FIXED o1:
  - Stream: header 0x12, warm-up 0x0064, then bits 00 0000 0000, then residual codes 001 01 1 (k=0).
  - iBlockSize=4 → 100, 101, 100, 100.
- Escape partition: FIXED o0, k=1111, n=3, residuals 011 101 → samples 3, −3. iEnable is toggled low mid-stream → identical output sequence.
- 4096-sample FIXED order-2 frame with p=4 and mixed k, compared against a software decoder → exactly 4096 strobes and a single frame-done.
- Unsupported type 0x40 → no oSampleValid, one oFrameDone. Reset asserted mid-frame and released → full correct re-decode from word 0.

Source files
------------

// File: rtl/flac_subframe_decoder.sv
// flac_subframe_decoder
// Decodes one FLAC subframe (16-bit samples, one channel) from a bitstream held
// in a synchronous RAM (1-cycle read latency, 16-bit words, MSB-first) and emits
// the reconstructed PCM samples one per strobe.
// Supported: CONSTANT, VERBATIM, FIXED orders 0..4 with partitioned Rice/Rice2
// residuals (including escape partitions).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | latch block size, start decoding
// S_HEADER   | read 8-bit subframe header, dispatch on type
// S_CONST    | read the constant value, then repeat it block-size times
// S_VERBATIM | emit raw 16-bit samples
// S_WARMUP   | emit `order` raw warm-up samples of a FIXED subframe
// S_RESID_HDR| read 2-bit coding method and 4-bit partition order
// S_PART_HDR | read Rice parameter (and escape width when escaped)
// S_RESIDUAL | decode residuals of the current partition, add prediction
// S_DONE     | pulse oFrameDone once, then stay silent until reset
//
// Ports:
//   iClock       rising-edge clock
//   iReset       asynchronous active-low reset
//   iEnable      high = run; low = hold all state including the RAM address
//   iBlockSize   samples in the subframe, latched in S_IDLE
//   iData        RAM read data for the address presented on the previous cycle
//   oReadAddr    RAM word address, starts at 0, only increments
//   oSample      decoded sample (low 16 bits of the 32-bit reconstruction)
//   oSampleValid one-cycle strobe qualifying oSample
//   oFrameDone   one-cycle strobe when the subframe is finished
module flac_subframe_decoder (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic [15:0]        iBlockSize,
  input  logic [15:0]        iData,
  output logic [15:0]        oReadAddr,
  output logic signed [15:0] oSample,
  output logic               oSampleValid,
  output logic               oFrameDone
);
  typedef enum logic [3:0] {
    S_IDLE, S_HEADER, S_CONST, S_VERBATIM, S_WARMUP,
    S_RESID_HDR, S_PART_HDR, S_RESIDUAL, S_DONE
  } state_t;

  state_t state, state_n;

  // Bit reader: left-aligned buffer, bits below bit_cnt are always zero.
  logic [31:0] bit_buf, shifted;
  logic [5:0]  bit_cnt, rem_cnt, nb;
  logic        primed, take;
  logic [15:0] addr;

  logic [15:0] blk, blk_n, samp_left, samp_left_n, part_left, part_left_n;
  logic [15:0] parts_left, parts_left_n, const_val, const_val_n;
  logic [2:0]  order, order_n, warm_left, warm_left_n;
  logic [3:0]  porder, porder_n;
  logic [4:0]  kparam, kparam_n, esc_bits, esc_bits_n, esc_code;
  logic [5:0]  kw, esc_sh;
  logic        method, method_n, escape, escape_n, esc_pend, esc_pend_n;
  logic        in_rem, in_rem_n, const_ok, const_ok_n, done_fired, done_fired_n;
  logic [31:0] quo, quo_n, u, esc_raw;
  logic signed [31:0] s1, s2, s3, s4, pred, resid, emit_val;
  logic        emit, frame_done;

  function automatic logic [31:0] fld(input logic [31:0] b, input logic [5:0] w);
    fld = b >> (6'd32 - w);   // w = 0 shifts everything out
  endfunction

  function automatic logic signed [31:0] unzig(input logic [31:0] v);
    unzig = $signed({1'b0, v[31:1]} ^ {32{v[0]}});
  endfunction

  assign oReadAddr = addr;
  assign rem_cnt   = bit_cnt - nb;
  assign shifted   = bit_buf << nb;
  // iData only reflects addr when addr was stable during the previous cycle.
  assign take      = primed && (rem_cnt <= 6'd16);
  assign kw        = method ? 6'd5 : 6'd4;
  assign esc_code  = method ? 5'd31 : 5'd15;
  assign esc_sh    = 6'd32 - {1'b0, esc_bits};

  always_comb begin
    case (order)
      3'd1:    pred = s1;
      3'd2:    pred = (s1 <<< 1) - s2;
      3'd3:    pred = 32'sd3 * s1 - 32'sd3 * s2 + s3;
      3'd4:    pred = (s1 <<< 2) - 32'sd6 * s2 + (s3 <<< 2) - s4;
      default: pred = '0;
    endcase
  end

  always_comb begin
    state_n = state;           blk_n = blk;               samp_left_n = samp_left;
    part_left_n = part_left;   parts_left_n = parts_left; const_val_n = const_val;
    order_n = order;           warm_left_n = warm_left;   porder_n = porder;
    kparam_n = kparam;         esc_bits_n = esc_bits;     method_n = method;
    escape_n = escape;         esc_pend_n = esc_pend;     in_rem_n = in_rem;
    const_ok_n = const_ok;     done_fired_n = done_fired; quo_n = quo;
    nb = '0; emit = 1'b0; emit_val = '0; frame_done = 1'b0;
    u = '0; esc_raw = '0; resid = '0;
    case (state)
      S_IDLE: begin
        blk_n = iBlockSize; samp_left_n = iBlockSize; state_n = S_HEADER;
      end
      S_HEADER: if (bit_cnt >= 6'd8) begin
        nb = 6'd8;   // bit 31 pad, bits 30:25 type, bit 24 wasted flag (ignored)
        if (bit_buf[30:25] == 6'd0) state_n = S_CONST;
        else if (bit_buf[30:25] == 6'd1) state_n = S_VERBATIM;
        else if (bit_buf[30:28] == 3'b001 && bit_buf[27:25] <= 3'd4) begin
          order_n = bit_buf[27:25]; warm_left_n = bit_buf[27:25]; state_n = S_WARMUP;
        end else state_n = S_DONE;
      end
      S_CONST: if (!const_ok) begin
        if (bit_cnt >= 6'd16) begin
          nb = 6'd16; const_val_n = bit_buf[31:16]; const_ok_n = 1'b1;
        end
      end else begin
        emit = 1'b1; emit_val = {{16{const_val[15]}}, const_val};
      end
      S_VERBATIM: if (bit_cnt >= 6'd16) begin
        nb = 6'd16; emit = 1'b1; emit_val = {{16{bit_buf[31]}}, bit_buf[31:16]};
      end
      S_WARMUP: if (warm_left == 3'd0) state_n = S_RESID_HDR;
      else if (bit_cnt >= 6'd16) begin
        nb = 6'd16; emit = 1'b1; emit_val = {{16{bit_buf[31]}}, bit_buf[31:16]};
        warm_left_n = warm_left - 3'd1;
      end
      S_RESID_HDR: if (bit_cnt >= 6'd6) begin
        nb = 6'd6;
        if (bit_buf[31]) state_n = S_DONE;
        else begin
          method_n = bit_buf[30]; porder_n = bit_buf[29:26];
          parts_left_n = 16'd1 << bit_buf[29:26];
          part_left_n = (blk >> bit_buf[29:26]) - {13'd0, order};
          esc_pend_n = 1'b0; state_n = S_PART_HDR;
        end
      end
      S_PART_HDR: if (!esc_pend) begin
        if (bit_cnt >= kw) begin
          nb = kw;
          kparam_n = method ? bit_buf[31:27] : {1'b0, bit_buf[31:28]};
          if (kparam_n == esc_code) esc_pend_n = 1'b1;
          else begin
            escape_n = 1'b0; in_rem_n = 1'b0; quo_n = '0; state_n = S_RESIDUAL;
          end
        end
      end else if (bit_cnt >= 6'd5) begin
        nb = 6'd5; esc_bits_n = bit_buf[31:27]; escape_n = 1'b1;
        esc_pend_n = 1'b0; state_n = S_RESIDUAL;
      end
      S_RESIDUAL: begin
        if (part_left == 16'd0) begin
          // partition 0 may legitimately be empty when its size equals the order
          if (parts_left <= 16'd1) state_n = S_DONE;
          else begin
            parts_left_n = parts_left - 16'd1; part_left_n = blk >> porder;
            state_n = S_PART_HDR;
          end
        end else if (escape) begin
          if (bit_cnt >= {1'b0, esc_bits}) begin
            nb = {1'b0, esc_bits};
            esc_raw = fld(bit_buf, {1'b0, esc_bits}) << esc_sh;
            resid = $signed(esc_raw) >>> esc_sh;
            emit = 1'b1;
          end
        end else if (!in_rem) begin
          if (bit_cnt != 6'd0) begin
            nb = 6'd1;
            if (!bit_buf[31]) quo_n = quo + 32'd1;
            else if (kparam == 5'd0) begin
              u = quo; resid = unzig(u); emit = 1'b1;
            end else in_rem_n = 1'b1;
          end
        end else if (bit_cnt >= {1'b0, kparam}) begin
          nb = {1'b0, kparam};
          u = (quo << kparam) | fld(bit_buf, {1'b0, kparam});
          resid = unzig(u); emit = 1'b1; in_rem_n = 1'b0;
        end
        if (emit) begin
          emit_val = pred + resid; part_left_n = part_left - 16'd1; quo_n = '0;
        end
      end
      S_DONE: if (!done_fired) begin
        frame_done = 1'b1; done_fired_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (emit) begin
      samp_left_n = samp_left - 16'd1;
      if (samp_left == 16'd1) state_n = S_DONE;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state <= S_IDLE; bit_buf <= '0; bit_cnt <= '0; primed <= 1'b0; addr <= '0;
      blk <= '0; samp_left <= '0; part_left <= '0; parts_left <= '0; const_val <= '0;
      order <= '0; warm_left <= '0; porder <= '0; kparam <= '0; esc_bits <= '0;
      method <= 1'b0; escape <= 1'b0; esc_pend <= 1'b0; in_rem <= 1'b0;
      const_ok <= 1'b0; done_fired <= 1'b0; quo <= '0;
      s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
      oSample <= '0; oSampleValid <= 1'b0; oFrameDone <= 1'b0;
    end else if (iEnable) begin
      state <= state_n; blk <= blk_n; samp_left <= samp_left_n;
      part_left <= part_left_n; parts_left <= parts_left_n; const_val <= const_val_n;
      order <= order_n; warm_left <= warm_left_n; porder <= porder_n;
      kparam <= kparam_n; esc_bits <= esc_bits_n; method <= method_n;
      escape <= escape_n; esc_pend <= esc_pend_n; in_rem <= in_rem_n;
      const_ok <= const_ok_n; done_fired <= done_fired_n; quo <= quo_n;
      bit_buf <= take ? (shifted | ({iData, 16'h0000} >> rem_cnt)) : shifted;
      bit_cnt <= rem_cnt + (take ? 6'd16 : 6'd0);
      primed  <= !take;
      if (take) addr <= addr + 16'd1;
      oSampleValid <= emit;
      oFrameDone   <= frame_done;
      if (emit) begin
        oSample <= emit_val[15:0];
        s1 <= emit_val; s2 <= s1; s3 <= s2; s4 <= s3;
      end
    end else begin
      oSampleValid <= 1'b0;
      oFrameDone   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_flac_subframe_decoder.sv
module tb_flac_subframe_decoder;
  logic               iClock = 1'b0;
  logic               iReset = 1'b0;
  logic               iEnable = 1'b0;
  logic [15:0]        iBlockSize = '0;
  logic [15:0]        iData = '0;
  logic [15:0]        oReadAddr;
  logic signed [15:0] oSample;
  logic               oSampleValid;
  logic               oFrameDone;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:16383];
  int wptr;

  int cyc = 0, last_valid_cyc = 0, done_cyc = 0, done_cnt = 0, start_cyc = 0;
  int got[$];
  int exp_q[$];

  flac_subframe_decoder dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iBlockSize(iBlockSize),
    .iData(iData), .oReadAddr(oReadAddr), .oSample(oSample),
    .oSampleValid(oSampleValid), .oFrameDone(oFrameDone)
  );

  always #5 iClock = ~iClock;

  always @(posedge iClock) iData <= mem[oReadAddr[13:0]];

  always @(negedge iClock) begin
    cyc++;
    if (oSampleValid) begin
      got.push_back(int'(oSample));
      last_valid_cyc = cyc;
    end
    if (oFrameDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    wptr = 0;
    exp_q.delete();
  endtask

  task automatic put_bits(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      mem[wptr >> 4][15 - (wptr & 15)] = v[i];
      wptr++;
    end
  endtask

  // Encoder model: builds a FIXED subframe with random warm-ups and residuals
  // in [-8, 8], k = partition index mod 5, one optional escape partition (n=5),
  // and records the samples a correct decoder must reproduce.
  task automatic gen_fixed(input int order, input int bs, input int p,
                           input int method, input int esc_part);
    int h[4];
    int e, pred, s, u, k, cnt, kw;
    logic [7:0] hdr;
    clear_mem();
    h = '{0, 0, 0, 0};
    kw = (method != 0) ? 5 : 4;
    hdr = {1'b0, 3'b001, 3'(order), 1'b0};
    put_bits({24'd0, hdr}, 8);
    for (int i = 0; i < order; i++) begin
      s = int'($urandom_range(0, 2000)) - 1000;
      put_bits(s, 16);
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = s;
      exp_q.push_back(s);
    end
    put_bits(method, 2);
    put_bits(p, 4);
    for (int part = 0; part < (1 << p); part++) begin
      cnt = (bs >> p) - ((part == 0) ? order : 0);
      k = part % 5;
      if (part == esc_part) begin
        put_bits((method != 0) ? 31 : 15, kw);
        put_bits(5, 5);
      end else put_bits(k, kw);
      for (int j = 0; j < cnt; j++) begin
        e = int'($urandom_range(0, 16)) - 8;
        if (part == esc_part) put_bits(e, 5);
        else begin
          u = (e >= 0) ? 2 * e : -2 * e - 1;
          for (int z = 0; z < (u >> k); z++) put_bits(0, 1);
          put_bits(1, 1);
          if (k > 0) put_bits(u, k);
        end
        case (order)
          1:       pred = h[0];
          2:       pred = 2 * h[0] - h[1];
          3:       pred = 3 * h[0] - 3 * h[1] + h[2];
          4:       pred = 4 * h[0] - 6 * h[1] + 4 * h[2] - h[3];
          default: pred = 0;
        endcase
        s = pred + e;
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = s;
        exp_q.push_back(int'($signed(s[15:0])));
      end
    end
  endtask

  task automatic run_frame(input int bs, input int budget, input bit toggle);
    iEnable = 1'b0;
    iReset = 1'b0;
    iBlockSize = bs[15:0];
    @(negedge iClock);
    @(negedge iClock);
    got.delete();
    done_cnt = 0;
    start_cyc = cyc;
    iReset = 1'b1;
    iEnable = 1'b1;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(negedge iClock);
      if (toggle) iEnable = ($urandom_range(0, 2) != 0);
    end
    iEnable = 1'b1;
    repeat (20) @(negedge iClock);
  endtask

  task automatic check_frame(input string tag, input bit chk_gap);
    chk({tag, ".count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s.sample[%0d]", tag, i), got[i], exp_q[i]);
    chk({tag, ".done_pulses"}, done_cnt, 1);
    if (chk_gap && exp_q.size() > 0)
      chk({tag, ".done_gap"}, done_cyc - last_valid_cyc, 1);
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge iClock);
    chk("reset.sample", int'(oSample), 0);
    chk("reset.valid", int'(oSampleValid), 0);
    chk("reset.done", int'(oFrameDone), 0);
    chk("reset.addr", int'(oReadAddr), 0);

    // CONSTANT: value 0xFFFE straddles words 0 and 1
    clear_mem();
    mem[0] = 16'h00FF; mem[1] = 16'hFE00;
    exp_q = '{-2, -2, -2, -2};
    run_frame(4, 2000, 1'b0);
    check_frame("const", 1'b1);

    // VERBATIM: extremes of the 16-bit range, misaligned by one byte
    clear_mem();
    mem[0] = 16'h027F; mem[1] = 16'hFF80; mem[2] = 16'h0000; mem[3] = 16'h0100;
    exp_q = '{32767, -32768, 1};
    run_frame(3, 2000, 1'b0);
    check_frame("verbatim", 1'b1);

    // FIXED order 1, k=0: residual codes 001 01 1 -> +1 -1 0
    clear_mem();
    mem[0] = 16'h1200; mem[1] = 16'h6400; mem[2] = 16'h0B00;
    exp_q = '{100, 101, 100, 100};
    run_frame(4, 2000, 1'b0);
    check_frame("fixed_o1", 1'b1);

    // FIXED order 0, escape partition with n=3: 011 101 -> 3, -3
    clear_mem();
    mem[0] = 16'h1003; mem[1] = 16'hC6E8;
    exp_q = '{3, -3};
    run_frame(2, 2000, 1'b0);
    check_frame("escape", 1'b1);
    run_frame(2, 4000, 1'b1);
    check_frame("escape_stall", 1'b0);

    // Unsupported type 0x40: no samples, a single prompt done
    clear_mem();
    mem[0] = 16'h4000;
    run_frame(4, 2000, 1'b0);
    check_frame("unsupported", 1'b0);
    chk("unsupported.latency_ok", int'((done_cyc - start_cyc) <= 8), 1);

    // Order 3 with enable stalls; order 4 with an empty partition 0 and an escape
    gen_fixed(3, 12, 1, 0, -1);
    run_frame(12, 4000, 1'b1);
    check_frame("fixed_o3", 1'b0);
    gen_fixed(4, 16, 2, 0, 2);
    run_frame(16, 4000, 1'b0);
    check_frame("fixed_o4", 1'b1);

    // Large FIXED order 2 frame, 16 partitions, 5-bit Rice parameters
    gen_fixed(2, 4096, 4, 1, 3);
    run_frame(4096, 60000, 1'b0);
    check_frame("fixed_o2_4096", 1'b1);

    // Reset mid-frame clears outputs at once, then a full re-decode
    gen_fixed(2, 256, 2, 1, 1);
    iEnable = 1'b0; iReset = 1'b0; iBlockSize = 16'd256;
    @(negedge iClock);
    iReset = 1'b1; iEnable = 1'b1;
    repeat (150) @(negedge iClock);
    chk("midreset.progress", int'(oReadAddr != 16'd0), 1);
    #2 iReset = 1'b0;
    #1;
    chk("midreset.addr", int'(oReadAddr), 0);
    chk("midreset.sample", int'(oSample), 0);
    chk("midreset.valid", int'(oSampleValid), 0);
    chk("midreset.done", int'(oFrameDone), 0);
    run_frame(256, 8000, 1'b0);
    check_frame("after_reset", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
